// File: rtl/ram256_arbiter.sv
// ram256_arbiter
//   Round-robin access controller for the 256x32 word RAM (four 64-word banks
//   selected by addr[7:6]; no decoding here, all 8 address bits pass through).
//   Two requesters issue single-word reads/writes. They are serialized onto the
//   RAM's single Address/Din/RW port. Read data is captured after READ_LAT
//   cycles, and each transaction completes with a one-cycle ack to its owner.
//
// Parameters
//   READ_LAT   cycles from RAM seeing a read address to Dout valid (1..3)
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   pN_req/we/addr/wdata       request N (held with stable fields until ack)
//   pN_ack                     one-cycle completion pulse for requester N
//   pN_rdata                   read data, valid in ack cycle, held until next read
//   ram_addr/ram_din/ram_rw    RAM command (ram_rw: 1 = read, 0 = write)
//   ram_dout                   RAM read data
//   busy                       high whenever the controller is not idle

// Per-requester completion state: ack pulse and sticky read data.
module ram256_arb_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,    // this port owns the current transaction
  input  logic        fin,    // transaction enters DONE at this edge
  input  logic        cap,    // ram_dout is valid at this edge (last WAIT cycle)
  input  logic [31:0] dout,
  output logic        ack,
  output logic [31:0] rdata
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= fin & sel;
      if (cap && sel) rdata <= dout;
    end
  end
endmodule

module ram256_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [7:0]  p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [7:0]  p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_rw,
  input  logic [31:0] ram_dout,
  output logic        busy
);
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } req_t;

  state_t                       state;
  logic                         ptr;     // preferred port when both request
  logic                         win;     // owner of the in-flight transaction
  logic                         cur_we;
  logic [1:0]                   cnt;     // read latency countdown
  logic [NUM_PORTS-1:0]         req_v;
  req_t [NUM_PORTS-1:0]         preq;
  logic                         nxt_win;
  logic                         fin;
  logic                         cap;
  logic [NUM_PORTS-1:0]         ack_v;
  logic [NUM_PORTS-1:0][31:0]   rdata_v;

  assign req_v   = {p1_req, p0_req};
  assign preq[0] = {p0_we, p0_addr, p0_wdata};
  assign preq[1] = {p1_we, p1_addr, p1_wdata};

  // Lone requester wins outright; a tie goes to the pointer.
  assign nxt_win = (&req_v) ? ptr : req_v[1];

  // Edge that moves the FSM into DONE; the last WAIT edge also carries read data.
  assign cap = (state == WAIT) && (cnt == 2'd1);
  assign fin = ((state == ISSUE) && cur_we) || cap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      win      <= 1'b0;
      cur_we   <= 1'b0;
      cnt      <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_rw   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_v) begin
            win      <= nxt_win;
            cur_we   <= preq[nxt_win].we;
            ram_addr <= preq[nxt_win].addr;
            ram_din  <= preq[nxt_win].wdata;
            ram_rw   <= ~preq[nxt_win].we;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // A write commits on the edge ending ISSUE; drop back to read right away.
          ram_rw <= 1'b1;
          if (cur_we) begin
            ptr   <= ~win;
            state <= DONE;
          end else begin
            cnt   <= 2'(READ_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            ptr   <= ~win;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    ram256_arb_port u_port (
      .clk   (clk),
      .rst_n (rst_n),
      .sel   (win == 1'(i)),
      .fin   (fin),
      .cap   (cap),
      .dout  (ram_dout),
      .ack   (ack_v[i]),
      .rdata (rdata_v[i])
    );
  end

  assign p0_ack   = ack_v[0];
  assign p1_ack   = ack_v[1];
  assign p0_rdata = rdata_v[0];
  assign p1_rdata = rdata_v[1];
endmodule

// File: tb/tb_ram256_arbiter.sv
// Testbench for ram256_arbiter: three instances (READ_LAT = 1, 2, 3), each
// driving its own behavioural 256x32 RAM with the matching read latency.
module tb_ram256_arbiter;
  logic        clk;
  logic        rst_n;
  logic [1:0]  req   [3];
  logic [1:0]  we    [3];
  logic [7:0]  addr  [3][2];
  logic [31:0] wdata [3][2];
  logic [1:0]  ack   [3];
  logic [31:0] rdata [3][2];
  logic [7:0]  ram_addr [3];
  logic [31:0] ram_din  [3];
  logic [2:0]  ram_rw;
  logic [31:0] ram_dout [3];
  logic [2:0]  busy;

  int total = 0;
  int npass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_inst
    logic [31:0] mem  [256];
    logic [31:0] pipe [3];

    ram256_arbiter #(.READ_LAT(k + 1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .p0_req   (req[k][0]),
      .p0_we    (we[k][0]),
      .p0_addr  (addr[k][0]),
      .p0_wdata (wdata[k][0]),
      .p0_ack   (ack[k][0]),
      .p0_rdata (rdata[k][0]),
      .p1_req   (req[k][1]),
      .p1_we    (we[k][1]),
      .p1_addr  (addr[k][1]),
      .p1_wdata (wdata[k][1]),
      .p1_ack   (ack[k][1]),
      .p1_rdata (rdata[k][1]),
      .ram_addr (ram_addr[k]),
      .ram_din  (ram_din[k]),
      .ram_rw   (ram_rw[k]),
      .ram_dout (ram_dout[k]),
      .busy     (busy[k])
    );

    // RAM: write on the edge while RW=0; Dout valid k+1 cycles after the address.
    always @(posedge clk) begin
      if (!ram_rw[k]) mem[ram_addr[k]] <= ram_din[k];
      pipe[0] <= mem[ram_addr[k]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign ram_dout[k] = pipe[k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One transaction on instance i, port p. Raised in an IDLE cycle; counts edges
  // until ack, checks the RAM command along the way, returns one cycle later idle.
  task automatic txn(input int i, input int p, input bit w, input logic [7:0] a,
                     input logic [31:0] d, input int exp_lat, input string tag,
                     output logic [31:0] rd);
    int n;
    logic [31:0] other;
    other = rdata[i][1-p];
    addr[i][p] = a; wdata[i][p] = d; we[i][p] = w; req[i][p] = 1'b1;
    n = 0;
    while (!ack[i][p] && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        chk({tag, "_addr_issue"}, 32'(ram_addr[i]), 32'(a));
        chk({tag, "_rw_issue"}, 32'(ram_rw[i]), 32'(!w));
        if (w) chk({tag, "_din"}, ram_din[i], d);
      end else if (!w && n < exp_lat) begin
        chk({tag, "_addr_wait"}, 32'(ram_addr[i]), 32'(a));
        chk({tag, "_rw_wait"}, 32'(ram_rw[i]), 32'd1);
      end
    end
    req[i][p] = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_other_ack"}, 32'(ack[i][1-p]), 32'd0);
    chk({tag, "_other_rdata"}, rdata[i][1-p], other);
    rd = rdata[i][p];
    @(posedge clk); #1;
    chk({tag, "_ack_pulse"}, 32'(ack[i][p]), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  exp_ack;
    logic [7:0]  bank_a [4];
    logic [31:0] bank_d [4];
    bank_a[0] = 8'h3F; bank_a[1] = 8'h40; bank_a[2] = 8'h80; bank_a[3] = 8'hFF;
    bank_d[0] = 32'h11111111; bank_d[1] = 32'h22222222;
    bank_d[2] = 32'h33333333; bank_d[3] = 32'h44444444;

    // Reset held two cycles with both requests asserted.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 2'b11; we[i] = 2'b11;
      for (int p = 0; p < 2; p++) begin
        addr[i][p] = 8'hAA; wdata[i][p] = 32'hFFFF0000;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ack", 32'(ack[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_rw", 32'(ram_rw[i]), 32'd1);
      chk("rst_addr", 32'(ram_addr[i]), 32'd0);
      chk("rst_din", ram_din[i], 32'd0);
      chk("rst_rdata0", rdata[i][0], 32'd0);
      chk("rst_rdata1", rdata[i][1], 32'd0);
      req[i] = 2'b00;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Port 0 write then read, READ_LAT = 1.
    txn(0, 0, 1'b1, 8'h00, 32'hDEADBEEF, 2, "p0_wr", rd);
    txn(0, 0, 1'b0, 8'h00, 32'h0, 3, "p0_rd", rd);
    chk("p0_rd_data", rd, 32'hDEADBEEF);
    chk("p1_rdata_idle", rdata[0][1], 32'd0);

    // Port 1 across all four banks.
    for (int b = 0; b < 4; b++) txn(0, 1, 1'b1, bank_a[b], bank_d[b], 2, "bank_wr", rd);
    for (int b = 0; b < 4; b++) begin
      txn(0, 1, 1'b0, bank_a[b], 32'h0, 3, "bank_rd", rd);
      chk("bank_rd_data", rd, bank_d[b]);
    end

    // Contention: both hold req; acks alternate p0,p1,... every 3 cycles.
    addr[0][0] = 8'h10; wdata[0][0] = 32'h00001010; we[0][0] = 1'b1;
    addr[0][1] = 8'h20; wdata[0][1] = 32'h00002020; we[0][1] = 1'b1;
    req[0] = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp_ack = (k % 3 == 2) ? (((k / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("cont_ack", 32'(ack[0]), 32'(exp_ack));
    end
    req[0] = 2'b00;
    @(posedge clk); #1;
    chk("cont_idle", 32'(busy[0]), 32'd0);
    txn(0, 0, 1'b0, 8'h10, 32'h0, 3, "cont_rd0", rd);
    chk("cont_rd0_data", rd, 32'h00001010);
    txn(0, 1, 1'b0, 8'h20, 32'h0, 3, "cont_rd1", rd);
    chk("cont_rd1_data", rd, 32'h00002020);

    // Latency sweep.
    txn(0, 0, 1'b1, 8'h5A, 32'hA5A5A5A5, 2, "lat1_wr", rd);
    txn(0, 0, 1'b0, 8'h5A, 32'h0, 3, "lat1_rd", rd);
    chk("lat1_data", rd, 32'hA5A5A5A5);
    txn(1, 0, 1'b1, 8'h5A, 32'hA5A5A5A5, 2, "lat2_wr", rd);
    txn(1, 0, 1'b0, 8'h5A, 32'h0, 4, "lat2_rd", rd);
    chk("lat2_data", rd, 32'hA5A5A5A5);
    txn(2, 1, 1'b1, 8'h5A, 32'hA5A5A5A5, 2, "lat3_wr", rd);
    txn(2, 1, 1'b0, 8'h5A, 32'h0, 5, "lat3_rd", rd);
    chk("lat3_data", rd, 32'hA5A5A5A5);

    // Reset during WAIT of a port-1 read.
    addr[0][1] = 8'h80; we[0][1] = 1'b0; req[0][1] = 1'b1;
    @(posedge clk); #1;   // ISSUE
    @(posedge clk); #1;   // WAIT
    chk("rstw_busy_pre", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    req[0][1] = 1'b0;
    chk("rstw_ack", 32'(ack[0]), 32'd0);
    chk("rstw_busy", 32'(busy[0]), 32'd0);
    chk("rstw_rdata1", rdata[0][1], 32'd0);
    chk("rstw_rw", 32'(ram_rw[0]), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstw_ack_after", 32'(ack[0]), 32'd0);
    txn(0, 0, 1'b1, 8'hC3, 32'hCAFEF00D, 2, "post_wr", rd);
    txn(0, 0, 1'b0, 8'hC3, 32'h0, 3, "post_rd", rd);
    chk("post_rd_data", rd, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end
endmodule
